// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue controller: FSM state encoding,
// ALU opcode constants, flag bit positions and the illegal-opcode test.
package alu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAP  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD         = 4'd0;
  localparam logic [3:0] OP_SUB         = 4'd1;
  localparam logic [3:0] OP_MUL         = 4'd2;
  localparam logic [3:0] OP_MOV         = 4'd7;
  localparam logic [3:0] OP_CMP         = 4'd11;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd13;

  // Positions inside the packed {N,Z,C,V} flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= OP_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   advance    : a grant is being consumed this cycle; move the pointer
//   grant[1:0] : one-hot grant (zero when nothing requests)
// The pointer names the port that wins a tie. It resets to port 0 and,
// after every consumed grant, points at the port that was not granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    // Granting port 0 hands priority to port 1 and vice versa.
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Accepts ALU requests from two ports, issues one at a time to an external
// registered ALU, captures its result and returns it to the requesting port.
//   reqN_valid/ready, reqN_opcode/op1/op2/imm : request ports 0 and 1
//   rsp_valid[1:0] (one-hot), rsp_ready[1:0]  : per-port response handshake
//   rsp_result, rsp_flags {N,Z,C,V}, rsp_err  : response payload
//   alu_opcode/op1/op2/imm -> ALU, alu_result/alu_flags <- ALU (1-cycle)
//   busy      : an operation is outstanding
//   dbg_state : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requests may be held or withdrawn freely while ready is low;
// a response, once valid, stays valid with a stable payload until taken.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter logic [3:0] IDLE_OPCODE = 4'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [6:0]        req0_imm,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [6:0]        req1_imm,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [6:0]        alu_imm,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              armed_q, armed_d;
  logic              busy_q, busy_d;
  logic [3:0]        alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
  logic [6:0]        alu_imm_q, alu_imm_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic              accept;
  logic [3:0]        sel_opcode;
  logic [DATA_W-1:0] sel_op1;
  logic [DATA_W-1:0] sel_op2;
  logic [6:0]        sel_imm;

  // armed_q is cleared by reset and set by the first clock edge after it, so
  // the earliest acceptance lands on the second edge with rst_n high and
  // reqN_ready is guaranteed low while reset is asserted.
  assign arb_req = (armed_q && (state_q == ST_IDLE)) ? {req1_valid, req0_valid} : 2'b00;
  assign accept  = (grant != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (accept),
    .grant   (grant)
  );

  assign sel_opcode = grant[1] ? req1_opcode : req0_opcode;
  assign sel_op1    = grant[1] ? req1_op1    : req0_op1;
  assign sel_op2    = grant[1] ? req1_op2    : req0_op2;
  assign sel_imm    = grant[1] ? req1_imm    : req0_imm;

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    armed_d      = 1'b1;
    // ALU inputs default to the idle MOV; only the EXEC cycle overrides them.
    alu_opcode_d = IDLE_OPCODE;
    alu_op1_d    = '0;
    alu_op2_d    = '0;
    alu_imm_d    = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          port_d = grant[1];
          if (is_illegal_op(sel_opcode)) begin
            // Rejected opcodes skip the ALU and answer on the next cycle.
            state_d      = ST_RESP;
            rsp_valid_d  = grant;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_flags_d  = '0;
          end else begin
            state_d      = ST_EXEC;
            alu_opcode_d = sel_opcode;
            alu_op1_d    = sel_op1;
            alu_op2_d    = sel_op2;
            alu_imm_d    = sel_imm;
            rsp_err_d    = 1'b0;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // The ALU registered the EXEC-cycle inputs on the previous edge.
        state_d      = ST_RESP;
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp_valid_d  = port_q ? 2'b10 : 2'b01;
      end
      ST_RESP: begin
        if (rsp_ready[port_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      port_q       <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      alu_opcode_q <= IDLE_OPCODE;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_imm_q    <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      armed_q      <= armed_d;
      busy_q       <= busy_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_imm_q    <= alu_imm_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_imm    = alu_imm_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl: a behavioural ALU on the alu_* pins, a
// cycle-level reference model of the issue controller with an expected
// response queue, directed scenarios and a randomized phase.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int         W       = 16;
  localparam logic [3:0] IDLE_OP = 4'd7;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_opcode = 0, req1_opcode = 0;
  logic [W-1:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic [6:0]   req0_imm = 0, req1_imm = 0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b11;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_op1, alu_op2;
  logic [6:0]   alu_imm;
  logic [W-1:0] alu_result = '0;
  logic [3:0]   alu_flags = '0;
  logic         busy;
  logic [1:0]   dbg_state;

  alu_issue_ctrl #(.DATA_W(W), .IDLE_OPCODE(IDLE_OP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_imm(req1_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  // Returns {result, N, Z, C, V}. C is carry-out for ADD and "no borrow"
  // for SUB/CMP. Other opcodes fold the immediate in so it is observable.
  function automatic logic [W+3:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [6:0] imm);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB, OP_CMP: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_MUL: r = a * b;
      default: r = (a ^ b) + {{(W-7){1'b0}}, imm};
    endcase
    return {r, r[W-1], (r == '0), c, v};
  endfunction

  always @(posedge clk) begin
    if (alu_opcode == OP_MOV) begin
      alu_result <= alu_op2;   // MOV leaves flags untouched
    end else begin
      {alu_result, alu_flags} <= alu_fn(alu_opcode, alu_op1, alu_op2, alu_imm);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic         port;
    logic         err;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [6:0]   imm;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  bit   m_ptr   = 1'b0;
  bit   m_run   = 1'b0;
  int   acc_port_log[$];
  int   acc_cyc_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model, evaluated once per cycle mid-period.
  // Model rules: one operation outstanding; legal ops respond 3 cycles after
  // the accept cycle, illegal ops after 1; the ALU sees the request only in
  // the cycle after the accept; ties go to the port that lost the last grant.
  always @(negedge clk) begin : mon
    logic [1:0] vv, exp_rdy, exp_rv;
    bit         pend, p;
    int         d;
    exp_t       e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 1'b0;
      m_run = 1'b0;
      check("rst_req_ready", {req1_ready, req0_ready}, 2'b00);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_alu_pins", {alu_opcode, alu_op1, alu_op2, alu_imm}, {IDLE_OP, 39'h0});
      check("rst_rsp_payload", {rsp_err, rsp_flags, rsp_result}, 0);
    end else begin
      pend = (exp_q.size() != 0);
      d    = cyc - acc_cyc;
      check("busy", busy, pend);
      if (pend && !exp_q[0].err && d == 1)
        check("alu_exec_pins", {alu_opcode, alu_op1, alu_op2, alu_imm},
              {exp_q[0].op, exp_q[0].a, exp_q[0].b, exp_q[0].imm});
      else
        check("alu_idle_pins", {alu_opcode, alu_op1, alu_op2, alu_imm}, {IDLE_OP, 39'h0});

      exp_rv = 2'b00;
      if (pend && d >= (exp_q[0].err ? 1 : 3)) exp_rv = exp_q[0].port ? 2'b10 : 2'b01;
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00) begin
        check("rsp_payload", {rsp_err, rsp_flags, rsp_result},
              {exp_q[0].err, exp_q[0].flg, exp_q[0].res});
        if (rsp_ready[exp_q[0].port]) void'(exp_q.pop_front());
      end

      vv      = {req1_valid, req0_valid};
      exp_rdy = 2'b00;
      if (!pend && m_run) exp_rdy = (vv == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : vv;
      check("req_ready", {req1_ready, req0_ready}, exp_rdy);
      if (exp_rdy != 2'b00) begin
        p     = exp_rdy[1];
        e.port = p;
        e.op   = p ? req1_opcode : req0_opcode;
        e.a    = p ? req1_op1 : req0_op1;
        e.b    = p ? req1_op2 : req0_op2;
        e.imm  = p ? req1_imm : req0_imm;
        e.err  = (e.op >= 4'd13);
        if (e.err) {e.res, e.flg} = '0;
        else       {e.res, e.flg} = alu_fn(e.op, e.a, e.b, e.imm);
        exp_q.push_back(e);
        acc_cyc = cyc;
        m_ptr   = ~p;
        acc_port_log.push_back(int'(p));
        acc_cyc_log.push_back(cyc);
      end
      m_run = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int p, input bit v, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [6:0] imm);
    if (p == 0) begin
      req0_valid = v; req0_opcode = op; req0_op1 = a; req0_op2 = b; req0_imm = imm;
    end else begin
      req1_valid = v; req1_opcode = op; req1_op1 = a; req1_op2 = b; req1_imm = imm;
    end
  endtask

  // Presents a request until accepted; returns one posedge+1 after the accept.
  task automatic issue(input int p, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [6:0] imm);
    bit ok = 1'b0;
    drive_req(p, 1'b1, op, a, b, imm);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    check("issue_accepted", ok, 1);
    @(posedge clk);
    #1;
    drive_req(p, 1'b0, 4'd0, '0, '0, '0);
  endtask

  task automatic wait_rsp(input logic [1:0] want, output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid == want) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_seen", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD overflow into the sign bit
    rsp_ready = 2'b11;
    issue(0, OP_ADD, 16'h7FFF, 16'h0001, 7'd0);
    wait_rsp(2'b01, lat);
    check("add_latency", lat, 3);
    check("add_result", rsp_result, 16'h8000);
    check("add_flags", rsp_flags, 4'b1001);
    wait_idle();

    // Fresh reset, both ports saturate with SUB 5-5
    do_reset();
    acc_port_log.delete();
    acc_cyc_log.delete();
    drive_req(0, 1'b1, OP_SUB, 16'd5, 16'd5, 7'd0);
    drive_req(1, 1'b1, OP_SUB, 16'd5, 16'd5, 7'd0);
    repeat (14) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) check("sub_rsp", {rsp_result, rsp_flags}, {16'h0000, 4'b0110});
    end
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, 4'd0, '0, '0, '0);
    drive_req(1, 1'b0, 4'd0, '0, '0, '0);
    check("sub_accept_count_ge3", acc_port_log.size() >= 3, 1);
    if (acc_port_log.size() >= 3) begin
      check("rr_order", {acc_port_log[0][1:0], acc_port_log[1][1:0], acc_port_log[2][1:0]}, 6'b00_01_00);
      check("issue_gap_0_1", acc_cyc_log[1] - acc_cyc_log[0], 4);
      check("issue_gap_1_2", acc_cyc_log[2] - acc_cyc_log[1], 4);
    end
    wait_idle();

    // Illegal opcode on port 1
    issue(1, 4'd14, 16'h1234, 16'h0000, 7'd0);
    wait_rsp(2'b10, lat);
    check("illegal_latency", lat, 1);
    check("illegal_err", rsp_err, 1);
    check("illegal_result", {rsp_result, rsp_flags}, 0);
    check("illegal_alu_opcode", alu_opcode, IDLE_OP);
    wait_idle();

    // CMP with a stalled response while port 1 waits; port 1's rsp_ready is
    // high throughout and must not complete port 0's response.
    rsp_ready = 2'b10;
    issue(0, OP_CMP, 16'd3, 16'd9, 7'd0);
    drive_req(1, 1'b1, OP_ADD, 16'd1, 16'd2, 7'd3);
    wait_rsp(2'b01, lat);
    check("cmp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("cmp_hold", {rsp_valid, rsp_result, rsp_flags}, {2'b01, 16'hFFFA, 4'b1000});
      check("req1_blocked", req1_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b01;
    @(negedge clk);
    check("cmp_handshake_cycle_req1", req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("req1_after_handshake", req1_ready, 1);
    @(posedge clk);
    #1;
    drive_req(1, 1'b0, 4'd0, '0, '0, '0);
    rsp_ready = 2'b11;
    wait_idle();

    // Reset during EXEC drops the operation
    issue(0, OP_ADD, 16'd10, 16'd20, 7'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 2'b00);
    check("midrst_alu_opcode", alu_opcode, IDLE_OP);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_ghost_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk);
    #1;
    issue(0, OP_SUB, 16'd9, 16'd4, 7'd0);
    wait_rsp(2'b01, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_result", {rsp_result, rsp_flags}, {16'd5, 4'b0010});
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      for (int p = 0; p < 2; p++) begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_MOV) op = OP_ADD;
        a = 16'($urandom);
        b = 16'($urandom);
        if ($urandom_range(0, 3) == 0) a = 16'h8000;
        if ($urandom_range(0, 3) == 0) b = 16'hFFFF;
        drive_req(p, ($urandom_range(0, 2) != 0), op, a, b, 7'($urandom_range(0, 127)));
      end
      rsp_ready = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    drive_req(0, 1'b0, 4'd0, '0, '0, '0);
    drive_req(1, 1'b0, 4'd0, '0, '0, '0);
    rsp_ready = 2'b11;
    wait_idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
